// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the byte-serial MIPS bus master.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } bus_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Word lane carrying byte k of a (len+1)-byte transfer.
    function automatic int unsigned lane_of(input int unsigned k,
                                            input int unsigned len,
                                            input logic        big_endian);
        return big_endian ? (len - k) : k;
    endfunction

endpackage

// File: rtl/mips_bus_master.sv
// Byte-serial bus master: turns one word request into 1..WORD_BYTES granted
// byte transfers on the shared 8-bit bus and returns a single-cycle response.
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int LEN_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_gpio,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LEN_W-1:0]        req_len,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*WORD_BYTES-1:0] rsp_rdata,
    output logic                    grant_request,
    input  logic                    grant_given,
    output logic                    rw,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic [ADDR_W:0]         address
);

    localparam int              DW      = 8 * WORD_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORD_BYTES - 1);

    bus_state_t        r_state;
    logic              r_write;
    logic              r_gpio;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_k;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     r_rdata;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DW-1:0]     r_rsp_rdata;
    logic              r_grant_request;
    logic              r_rw;
    logic [7:0]        r_data_out;
    logic [ADDR_W:0]   r_address;

    logic              w_accept;
    logic [LEN_W-1:0]  w_req_len;
    logic              w_last;
    logic [LEN_W-1:0]  w_k_next;
    logic [DW-1:0]     w_rdata_cap;
    logic [7:0]        w_first_wbyte;
    logic [7:0]        w_next_wbyte;

    assign w_accept  = req_valid && r_req_ready;
    assign w_req_len = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    assign w_last    = (r_k == r_len);
    assign w_k_next  = r_k + 1'b1;

    assign w_first_wbyte = req_wdata[8*lane_of(0, 32'(w_req_len), BIG_ENDIAN) +: 8];
    assign w_next_wbyte  = r_wdata[8*lane_of(32'(w_k_next), 32'(r_len), BIG_ENDIAN) +: 8];

    // NOTE: default assignment first so the partial lane update cannot infer a latch.
    always_comb begin
        w_rdata_cap = r_rdata;
        w_rdata_cap[8*lane_of(32'(r_k), 32'(r_len), BIG_ENDIAN) +: 8] = data_in;
    end

    // Bus outputs are registered, so each edge loads the values for the next cycle.
    // NOTE: non-blocking assignments keep every register update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_write         <= RW_READ;
            r_gpio          <= 1'b0;
            r_base          <= '0;
            r_len           <= '0;
            r_k             <= '0;
            r_wdata         <= '0;
            r_rdata         <= '0;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_rsp_rdata     <= '0;
            r_grant_request <= 1'b0;
            r_rw            <= RW_READ;
            r_data_out      <= '0;
            r_address       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state         <= BUSY;
                        r_write         <= req_write;
                        r_gpio          <= req_gpio;
                        r_base          <= req_addr;
                        r_len           <= w_req_len;
                        r_wdata         <= req_wdata;
                        r_k             <= '0;
                        r_rdata         <= '0;
                        r_req_ready     <= 1'b0;
                        r_grant_request <= 1'b1;
                        r_rw            <= req_write;
                        r_address       <= {req_gpio, req_addr};
                        r_data_out      <= w_first_wbyte;
                    end
                end
                BUSY: begin
                    if (grant_given) begin
                        if (r_write == RW_READ) begin
                            r_rdata <= w_rdata_cap;
                        end
                        if (w_last) begin
                            r_state         <= RESP;
                            r_rsp_valid     <= 1'b1;
                            if (r_write == RW_READ) begin
                                r_rsp_rdata <= w_rdata_cap;
                            end
                            r_grant_request <= 1'b0;
                            r_rw            <= RW_READ;
                            r_data_out      <= '0;
                            r_address       <= '0;
                        end else begin
                            r_k        <= w_k_next;
                            r_address  <= {r_gpio, r_base + ADDR_W'(w_k_next)};
                            r_data_out <= w_next_wbyte;
                        end
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign grant_request = r_grant_request;
    assign rw            = r_rw;
    assign data_out      = r_data_out;
    assign address       = r_address;

endmodule
